// File: rtl/x1_sram_arbiter_if.sv
// Signal bundle around the X1 SRAM arbiter: video read port, CPU ports and SRAM pins.
// slave = the arbiter itself, master = the surrounding system (core buses + board SRAM).
interface x1_sram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int NCH    = 2
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic                      I_V_REQ;
  logic [ADDR_W-1:0]         I_V_A;
  logic [DATA_W*LANES-1:0]   O_V_D;
  logic                      O_V_ACK;

  logic [NCH-1:0]            I_C_REQ;
  logic [NCH-1:0]            I_C_WE;
  logic [NCH*ADDR_W-1:0]     I_C_A;
  logic [NCH*LANE_W-1:0]     I_C_LANE;
  logic [NCH*DATA_W-1:0]     I_C_D;
  logic [DATA_W-1:0]         O_C_D;
  logic [NCH-1:0]            O_C_ACK;

  logic [ADDR_W-1:0]         O_SRAM_A;
  logic [DATA_W*LANES-1:0]   O_SRAM_D;
  logic [DATA_W*LANES-1:0]   I_SRAM_D;
  logic                      O_SRAM_WE;
  logic                      O_SRAM_OE;
  logic [LANES-1:0]          O_SRAM_BW;

  modport slave (
    input  I_V_REQ, I_V_A, I_C_REQ, I_C_WE, I_C_A, I_C_LANE, I_C_D, I_SRAM_D,
    output O_V_D, O_V_ACK, O_C_D, O_C_ACK,
           O_SRAM_A, O_SRAM_D, O_SRAM_WE, O_SRAM_OE, O_SRAM_BW
  );

  modport master (
    output I_V_REQ, I_V_A, I_C_REQ, I_C_WE, I_C_A, I_C_LANE, I_C_D, I_SRAM_D,
    input  O_V_D, O_V_ACK, O_C_D, O_C_ACK,
           O_SRAM_A, O_SRAM_D, O_SRAM_WE, O_SRAM_OE, O_SRAM_BW
  );
endinterface

// File: rtl/x1_sram_arbiter.sv
// Time-multiplexes one async SRAM between a priority video read port and NCH round-robin CPU ports.
// Each access is IDLE(arbitrate) -> ACCESS(ACC_CYC clocks) -> DONE(ack pulse); all SRAM pins are registered.
module x1_sram_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 8,
  parameter int LANES   = 4,
  parameter int NCH     = 2,
  parameter int ACC_CYC = 2,
  parameter int VID_MAX = 3
) (
  input  logic             I_CLK,
  input  logic             I_RESET,
  x1_sram_arbiter_if.slave bus
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W  = $clog2(ACC_CYC);
  localparam int STK_W  = (VID_MAX > 0) ? $clog2(VID_MAX + 1) : 1;
  localparam int WORD_W = DATA_W * LANES;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYC - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(VID_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [STK_W-1:0]    r_streak;
  logic [CH_W-1:0]     r_ptr;
  logic                r_own_vid;
  logic [CH_W-1:0]     r_own_ch;
  logic                r_we;
  logic [LANE_W-1:0]   r_lane;

  logic [ADDR_W-1:0]   r_sram_a;
  logic [WORD_W-1:0]   r_sram_d;
  logic                r_sram_we;
  logic                r_sram_oe;
  logic [LANES-1:0]    r_sram_bw;
  logic [WORD_W-1:0]   r_v_d;
  logic                r_v_ack;
  logic [DATA_W-1:0]   r_c_d;
  logic [NCH-1:0]      r_c_ack;

  logic                w_cpu_pend;
  logic                w_vid_win;
  logic [CH_W-1:0]     w_sel;
  logic [CH_W-1:0]     w_sel_next;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_a;
  logic [LANE_W-1:0]   w_sel_lane;
  logic [DATA_W-1:0]   w_sel_d;

  function automatic logic [CH_W-1:0] f_wrap(input int v);
    return CH_W'(v % NCH);
  endfunction

  // Scan offsets high to low so the closest requester at/after the pointer wins.
  always_comb begin
    w_cpu_pend = |bus.I_C_REQ;
    w_vid_win  = bus.I_V_REQ && (!w_cpu_pend || (r_streak < STK_MAX));
    w_sel      = r_ptr;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.I_C_REQ[f_wrap(int'(r_ptr) + i)]) begin
        w_sel = f_wrap(int'(r_ptr) + i);
      end
    end
    w_sel_next = f_wrap(int'(w_sel) + 1);
    w_sel_we   = bus.I_C_WE[w_sel];
    w_sel_a    = bus.I_C_A[w_sel*ADDR_W +: ADDR_W];
    w_sel_lane = bus.I_C_LANE[w_sel*LANE_W +: LANE_W];
    w_sel_d    = bus.I_C_D[w_sel*DATA_W +: DATA_W];
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_streak  <= '0;
      r_ptr     <= '0;
      r_own_vid <= 1'b0;
      r_own_ch  <= '0;
      r_we      <= 1'b0;
      r_lane    <= '0;
      r_sram_a  <= '0;
      r_sram_d  <= '0;
      r_sram_we <= 1'b0;
      r_sram_oe <= 1'b0;
      r_sram_bw <= '0;
      r_v_d     <= '0;
      r_v_ack   <= 1'b0;
      r_c_d     <= '0;
      r_c_ack   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_vid_win) begin
            r_state   <= S_ACCESS;
            r_cnt     <= '0;
            r_own_vid <= 1'b1;
            r_we      <= 1'b0;
            r_lane    <= '0;
            r_sram_a  <= bus.I_V_A;
            r_sram_oe <= 1'b1;
            r_sram_bw <= {LANES{1'b1}};
            if (!w_cpu_pend) begin
              r_streak <= '0;
            end else if (r_streak != STK_MAX) begin
              r_streak <= r_streak + 1'b1;
            end
          end else if (w_cpu_pend) begin
            r_state   <= S_ACCESS;
            r_cnt     <= '0;
            r_own_vid <= 1'b0;
            r_own_ch  <= w_sel;
            r_we      <= w_sel_we;
            r_lane    <= w_sel_lane;
            r_sram_a  <= w_sel_a;
            r_sram_d  <= {LANES{w_sel_d}};
            r_sram_oe <= !w_sel_we;
            r_sram_bw <= w_sel_we ? (LANES'(1) << w_sel_lane) : {LANES{1'b1}};
            r_ptr     <= w_sel_next;
            r_streak  <= '0;
          end else begin
            r_streak <= '0;
          end
        end

        // WE is held off in cycle 0 for address setup and drops at the same edge as BW/OE.
        S_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state   <= S_DONE;
            r_sram_we <= 1'b0;
            r_sram_oe <= 1'b0;
            r_sram_bw <= '0;
            if (r_own_vid) begin
              r_v_ack <= 1'b1;
              r_v_d   <= bus.I_SRAM_D;
            end else begin
              r_c_ack <= NCH'(1) << r_own_ch;
              if (!r_we) begin
                r_c_d <= bus.I_SRAM_D[r_lane*DATA_W +: DATA_W];
              end
            end
          end else begin
            r_sram_we <= r_we;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_v_ack <= 1'b0;
          r_c_ack <= '0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.O_SRAM_A  = r_sram_a;
  assign bus.O_SRAM_D  = r_sram_d;
  assign bus.O_SRAM_WE = r_sram_we;
  assign bus.O_SRAM_OE = r_sram_oe;
  assign bus.O_SRAM_BW = r_sram_bw;
  assign bus.O_V_D     = r_v_d;
  assign bus.O_V_ACK   = r_v_ack;
  assign bus.O_C_D     = r_c_d;
  assign bus.O_C_ACK   = r_c_ack;
endmodule

// File: tb/tb_x1_sram_arbiter.sv
// Directed bench for x1_sram_arbiter with NCH=4, ACC_CYC=2, VID_MAX=3 and a behavioural SRAM.
// Expected values are hand-computed from the SRAM contents below.
module tb_x1_sram_arbiter;
  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 8;
  localparam int LANES   = 4;
  localparam int NCH     = 4;
  localparam int ACC_CYC = 2;
  localparam int VID_MAX = 3;
  localparam int LANE_W  = 2;
  localparam int VID     = 99;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  x1_sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES), .NCH(NCH)) bus ();

  x1_sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES),
    .NCH(NCH), .ACC_CYC(ACC_CYC), .VID_MAX(VID_MAX)
  ) dut (
    .I_CLK  (clk),
    .I_RESET(rst),
    .bus    (bus)
  );

  // 0x00100 holds 0x44332211; every other word is derived from its address.
  function automatic logic [31:0] sram_word(input logic [17:0] a);
    if (a == 18'h00100) return 32'h44332211;
    return {a[7:0] ^ 8'hF0, a[15:8], 8'h96, a[7:0]};
  endfunction

  always_comb bus.I_SRAM_D = bus.O_SRAM_OE ? sram_word(bus.O_SRAM_A) : 32'h0;

  int n_cmp = 0;
  int n_err = 0;
  int n_overlap = 0;
  int ack_log[$];
  int acc_cnt, oe_cnt, we_cnt, we_at;
  logic [3:0]  bw_or;
  logic [31:0] we_d;
  logic [17:0] we_a;
  logic [31:0] last_vd;
  int lat;

  int exp_starve[8] = '{VID, VID, VID, 0, VID, VID, VID, 0};
  int exp_rr[5]     = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_stats();
    ack_log.delete();
    acc_cnt = 0; oe_cnt = 0; we_cnt = 0; we_at = 0;
    bw_or = '0; we_d = '0; we_a = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.O_V_ACK) begin
      ack_log.push_back(VID);
      last_vd = bus.O_V_D;
    end
    for (int k = 0; k < NCH; k++) if (bus.O_C_ACK[k]) ack_log.push_back(k);
    if ($countones({bus.O_V_ACK, bus.O_C_ACK}) > 1) n_overlap++;
    if (bus.O_SRAM_BW != 0) begin
      acc_cnt++;
      bw_or = bw_or | bus.O_SRAM_BW;
    end
    if (bus.O_SRAM_OE) oe_cnt++;
    if (bus.O_SRAM_WE) begin
      we_cnt++;
      we_at = acc_cnt;
      we_d  = bus.O_SRAM_D;
      we_a  = bus.O_SRAM_A;
    end
  endtask

  task automatic wait_ack(input int bound, output int n);
    n = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      n++;
      if (bus.O_V_ACK || (bus.O_C_ACK != 0)) return;
    end
    n = -1;
  endtask

  task automatic run_until(input int n, input int bound, input bit drop);
    for (int i = 0; i < bound && ack_log.size() < n; i++) begin
      tick();
      if (drop) bus.I_C_REQ = bus.I_C_REQ & ~bus.O_C_ACK;
    end
  endtask

  task automatic set_ch(input int k, input logic we, input logic [17:0] a,
                        input logic [1:0] lane, input logic [7:0] d);
    bus.I_C_WE[k] = we;
    bus.I_C_A[k*ADDR_W +: ADDR_W]    = a;
    bus.I_C_LANE[k*LANE_W +: LANE_W] = lane;
    bus.I_C_D[k*DATA_W +: DATA_W]    = d;
  endtask

  function automatic int log_at(input int i);
    return (i < ack_log.size()) ? ack_log[i] : -1;
  endfunction

  initial begin
    rst = 1'b1;
    bus.I_V_REQ = 1'b0; bus.I_V_A = '0;
    bus.I_C_REQ = '0; bus.I_C_WE = '0; bus.I_C_A = '0; bus.I_C_LANE = '0; bus.I_C_D = '0;
    last_vd = '0;
    reset_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_v_ack", bus.O_V_ACK, 0);
    chk("rst_c_ack", bus.O_C_ACK, 0);
    chk("rst_we_oe_bw", {bus.O_SRAM_WE, bus.O_SRAM_OE, bus.O_SRAM_BW}, 0);
    chk("rst_sram_a", bus.O_SRAM_A, 0);
    chk("rst_sram_d", bus.O_SRAM_D, 0);
    chk("rst_v_d", bus.O_V_D, 0);
    chk("rst_c_d", bus.O_C_D, 0);
    rst = 1'b0;
    tick();

    // Single CPU read: ch0, lane 2 of 0x44332211.
    reset_stats();
    set_ch(0, 1'b0, 18'h00100, 2'd2, 8'h00);
    bus.I_C_REQ = 4'b0001;
    wait_ack(20, lat);
    chk("rd_lat", lat, 3);
    chk("rd_ack", bus.O_C_ACK, 4'b0001);
    chk("rd_data", bus.O_C_D, 8'h33);
    bus.I_C_REQ = '0;
    tick(); tick();
    chk("rd_oe_cycles", oe_cnt, 2);
    chk("rd_we_cycles", we_cnt, 0);
    chk("rd_bw", bw_or, 4'hF);

    // CPU write: ch1, lane 3, 0xA5 to the top address.
    reset_stats();
    set_ch(1, 1'b1, 18'h3FFFF, 2'd3, 8'hA5);
    bus.I_C_REQ = 4'b0010;
    wait_ack(20, lat);
    chk("wr_lat", lat, 3);
    chk("wr_ack", bus.O_C_ACK, 4'b0010);
    chk("wr_cd_held", bus.O_C_D, 8'h33);
    bus.I_C_REQ = '0;
    tick(); tick();
    chk("wr_bw", bw_or, 4'b1000);
    chk("wr_acc_cycles", acc_cnt, 2);
    chk("wr_we_cycles", we_cnt, 1);
    chk("wr_we_position", we_at, 2);
    chk("wr_oe_cycles", oe_cnt, 0);
    chk("wr_sram_d", we_d, 32'hA5A5A5A5);
    chk("wr_sram_a", we_a, 18'h3FFFF);

    // Video starvation limit: video and ch0 held continuously.
    reset_stats();
    set_ch(0, 1'b0, 18'h00100, 2'd0, 8'h00);
    bus.I_V_A = 18'h00200;
    bus.I_V_REQ = 1'b1;
    bus.I_C_REQ = 4'b0001;
    run_until(8, 100, 1'b0);
    bus.I_V_REQ = 1'b0;
    bus.I_C_REQ = '0;
    chk("starve_count", ack_log.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("starve_order[%0d]", i), log_at(i), exp_starve[i]);
    chk("starve_v_d", last_vd, 32'hF0029600);
    chk("starve_c_d", bus.O_C_D, 8'h11);
    tick(); tick();

    // Reset during the WE cycle of a write.
    reset_stats();
    set_ch(1, 1'b1, 18'h00ABC, 2'd0, 8'h5E);
    bus.I_C_REQ = 4'b0010;
    tick(); tick();
    chk("mid_we_before", bus.O_SRAM_WE, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("mid_pins_async", {bus.O_SRAM_WE, bus.O_SRAM_OE, bus.O_SRAM_BW}, 0);
    bus.I_C_REQ = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    reset_stats();
    repeat (6) tick();
    chk("mid_no_ack", ack_log.size(), 0);
    set_ch(3, 1'b0, 18'h00100, 2'd1, 8'h00);
    bus.I_C_REQ = 4'b1000;
    wait_ack(20, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_ack", bus.O_C_ACK, 4'b1000);
    chk("post_rst_data", bus.O_C_D, 8'h22);
    bus.I_C_REQ = '0;
    tick(); tick();

    // Round robin with the pointer wrapped back to channel 0.
    for (int k = 0; k < NCH; k++) set_ch(k, 1'b0, 18'h00100, 2'(k), 8'h00);
    reset_stats();
    bus.I_C_REQ = 4'b1111;
    run_until(5, 100, 1'b0);
    bus.I_C_REQ = '0;
    chk("rr_count", ack_log.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_order[%0d]", i), log_at(i), exp_rr[i]);
    tick(); tick();
    reset_stats();
    bus.I_C_REQ = 4'b0101;
    run_until(2, 50, 1'b1);
    chk("rr_ptr1_first", log_at(0), 2);
    chk("rr_ptr1_second", log_at(1), 0);
    tick(); tick();

    // Request withdrawn right after grant still completes.
    reset_stats();
    set_ch(0, 1'b0, 18'h00100, 2'd3, 8'h00);
    bus.I_C_REQ = 4'b0001;
    tick();
    bus.I_C_REQ = '0;
    wait_ack(20, lat);
    chk("drop_lat", lat, 2);
    chk("drop_ack", bus.O_C_ACK, 4'b0001);
    chk("drop_data", bus.O_C_D, 8'h44);
    tick(); tick();

    // One-cycle pulse on ch2 while ch1 is being served is never acked.
    reset_stats();
    set_ch(1, 1'b0, 18'h00200, 2'd1, 8'h00);
    set_ch(2, 1'b0, 18'h00100, 2'd0, 8'h00);
    bus.I_C_REQ = 4'b0010;
    tick();
    bus.I_C_REQ = 4'b0110;
    tick();
    bus.I_C_REQ = 4'b0010;
    run_until(1, 20, 1'b1);
    repeat (10) tick();
    chk("pulse_count", ack_log.size(), 1);
    chk("pulse_owner", log_at(0), 1);
    chk("pulse_data", bus.O_C_D, 8'h96);

    chk("ack_overlap", n_overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
